// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon colour sequencer.
// Colour codes are 1..4 for colours 0..3; 0 marks an empty slot.
package simon_pkg;

  typedef logic [2:0] colour_t;

  localparam colour_t COL_NONE = 3'd0;
  localparam colour_t COL_0    = 3'd1;
  localparam colour_t COL_1    = 3'd2;
  localparam colour_t COL_2    = 3'd3;
  localparam colour_t COL_3    = 3'd4;

  localparam int          LEN_DEFAULT = 32;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {IDLE, GEN, ON, OFF} seq_state_t;

  // One-hot LED for a colour code; an empty slot lights nothing.
  function automatic logic [3:0] colour_led(colour_t c);
    if (c == COL_NONE) return 4'b0000;
    return 4'b0001 << (c - 3'd1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loads seed on reset and steps every clock.
module lfsr16
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= seed;
    else          q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/simon_sequencer.sv
// Generates the Simon colour sequence and plays entries 0..round back on the LEDs.
// new_game/show are one-cycle requests accepted only in IDLE; busy high means a request is dropped.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int          LEN        = LEN_DEFAULT,
  parameter int          ON_CYCLES  = 50_000_000,
  parameter int          OFF_CYCLES = 25_000_000,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                new_game,
  input  logic                show,
  input  logic [4:0]          round,
  output logic [LEN-1:0][2:0] segment,
  output logic                seg_valid,
  output logic [3:0]          led,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam int IW   = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int DMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  seq_state_t    state, state_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] round_eff;
  logic [IW-1:0] round_clamp;
  logic [DW-1:0] dwell;
  logic [15:0]   lfsr_q;
  logic          done_n;

  lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (SEED),
    .q       (lfsr_q)
  );

  always_comb begin
    round_clamp = IW'(round);
    if (int'(round) > LEN - 1) round_clamp = IW'(LEN - 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (new_game)               state_n = GEN;
        else if (show && seg_valid) state_n = ON;
      end
      GEN: if (idx == IW'(LEN - 1)) state_n = IDLE;
      ON:  if (dwell == DW'(ON_CYCLES - 1)) state_n = OFF;
      OFF: begin
        if (dwell == DW'(OFF_CYCLES - 1)) begin
          if (idx == round_eff) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = ON;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      round_eff <= '0;
      dwell     <= '0;
      segment   <= '0;
      seg_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_n;
      // Dwell only runs inside a lit/dark period and restarts on every state change.
      if (state_n != state || state == IDLE || state == GEN) dwell <= '0;
      else                                                   dwell <= dwell + 1'b1;
      case (state)
        IDLE: begin
          if (state_n == GEN) begin
            seg_valid <= 1'b0;
            idx       <= '0;
          end else if (state_n == ON) begin
            idx       <= '0;
            round_eff <= round_clamp;
          end
        end
        GEN: begin
          segment[idx] <= {1'b0, lfsr_q[1:0]} + 3'd1;
          idx          <= idx + 1'b1;
          if (state_n == IDLE) seg_valid <= 1'b1;
        end
        OFF: if (state_n == ON) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    led = 4'b0000;
    if (state == ON) led = colour_led(segment[idx]);
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: expected per-cycle {busy,done,led} traces and
// sequence words are queued by the drivers and checked by an independent monitor.
module tb_simon_sequencer;

  localparam int LEN = 32;
  localparam int ONC = 3;
  localparam int OFFC = 2;

  logic                clk = 1'b0;
  logic                reset_n = 1'b1;
  logic                new_game = 1'b0;
  logic                show = 1'b0;
  logic [4:0]          round = 5'd0;
  logic [LEN-1:0][2:0] segment;
  logic                seg_valid;
  logic [3:0]          led;
  logic                busy;
  logic                done;
  logic [1:0]          state_dbg;

  simon_sequencer #(.LEN(LEN), .ON_CYCLES(ONC), .OFF_CYCLES(OFFC), .SEED(16'hACE1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .new_game  (new_game),
    .show      (show),
    .round     (round),
    .segment   (segment),
    .seg_valid (seg_valid),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic [5:0]  exp_q[$];
  logic [95:0] seg_q[$];
  logic [2:0]  exp_seg [LEN];
  logic [15:0] lfsr_m;
  logic        sv_prev = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] onehot(input logic [2:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << (c - 3'd1);
  endfunction

  function automatic logic [95:0] pack_seg();
    logic [95:0] w;
    w = '0;
    for (int i = 0; i < LEN; i++) w[3*i +: 3] = exp_seg[i];
    return w;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_m <= 16'hACE1;
    else          lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [5:0] e;
    logic       ok;
    if (reset_n) begin
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_activity", {busy, done, led}, 6'd0);
        end else begin
          e = exp_q.pop_front();
          check("trace", {busy, done, led}, e);
        end
      end
      if (seg_valid && !sv_prev) begin
        ok = 1'b1;
        for (int i = 0; i < LEN; i++)
          if (segment[i] == 3'd0 || segment[i] > 3'd4) ok = 1'b0;
        check("seg_range", ok, 1'b1);
        if (seg_q.size() == 0) check("unexpected_seg_valid", seg_valid, 1'b0);
        else                   check("seg_word", segment, seg_q.pop_front());
      end
      sv_prev = seg_valid;
    end else begin
      sv_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic check_cleared(input string tag);
    check({tag, "_segment"}, segment, 96'd0);
    check({tag, "_seg_valid"}, seg_valid, 1'b0);
    check({tag, "_led"}, led, 4'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_state"}, state_dbg, 2'd0);
  endtask

  task automatic do_reset(input string tag);
    #1 reset_n = 1'b0;
    new_game = 1'b0;
    show = 1'b0;
    exp_q.delete();
    seg_q.delete();
    #1 check_cleared(tag);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || seg_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() + seg_q.size(), 0);
  endtask

  task automatic gen(input bit with_show, input int abort_at);
    for (int i = 0; i < LEN; i++) exp_q.push_back(6'b10_0000);
    @(negedge clk);
    new_game = 1'b1;
    show = with_show;
    @(negedge clk);
    new_game = 1'b0;
    show = 1'b0;
    for (int j = 0; j < LEN; j++) begin
      if (j == abort_at) begin
        do_reset("gen_abort");
        return;
      end
      exp_seg[j] = {1'b0, lfsr_m[1:0]} + 3'd1;
      if (j < LEN - 1) @(negedge clk);
    end
    seg_q.push_back(pack_seg());
    drain(10);
  endtask

  task automatic play(input logic [4:0] r, input int change_at, input logic [4:0] r_new,
                      input int ng_at, input int abort_at);
    int re;
    int total;
    re = (r > 5'd31) ? 31 : int'(r);
    for (int i = 0; i <= re; i++) begin
      repeat (ONC)  exp_q.push_back({2'b10, onehot(exp_seg[i])});
      repeat (OFFC) exp_q.push_back(6'b10_0000);
    end
    exp_q.push_back(6'b01_0000);
    total = (re + 1) * (ONC + OFFC) + 1;
    @(negedge clk);
    show = 1'b1;
    round = r;
    @(negedge clk);
    show = 1'b0;
    for (int t = 0; t < total; t++) begin
      if (t == abort_at) begin
        do_reset("play_abort");
        return;
      end
      if (t == change_at) round = r_new;
      new_game = (t == ng_at);
      @(negedge clk);
    end
    new_game = 1'b0;
    drain(10);
  endtask

  // watchdog
  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    do_reset("reset");

    // show before any sequence exists is dropped
    @(negedge clk);
    show = 1'b1;
    round = 5'd2;
    @(negedge clk);
    show = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("ignored_show_led", led, 4'd0);
      check("ignored_show_busy", busy, 1'b0);
    end

    gen(1'b0, -1);
    play(5'd2, -1, 5'd0, -1, -1);
    play(5'd31, -1, 5'd0, -1, -1);

    // simultaneous requests: generation wins
    gen(1'b1, -1);

    // new_game and a round change during playback have no effect
    play(5'd1, 2, 5'd31, 1, -1);
    check("seg_unchanged", segment, pack_seg());
    check("seg_valid_kept", seg_valid, 1'b1);

    // async reset mid-generation, then mid-playback
    gen(1'b0, 10);
    gen(1'b0, -1);
    play(5'd2, -1, 5'd0, -1, 6);
    gen(1'b0, -1);
    play(5'd0, -1, 5'd0, -1, -1);

    repeat (3) @(negedge clk);
    check("final_queues_empty", exp_q.size() + seg_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Generates the random colour sequence for a Simon game and plays the first round+1 entries back on the LEDs. It sits directly upstream of `verify_input`. It drives the `segment` array that `verify_input` compares player presses against, and it shows the player which colours to repeat before each check round.

## Interface
Parameters:
- `LEN`, 32, sequence length (entries in `segment`)
- `ON_CYCLES`, 50_000_000, clocks each LED stays lit during playback
- `OFF_CYCLES`, 25_000_000, dark clocks after each lit entry
- `SEED`, 16'hACE1, LFSR reset value (must be non-zero)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock
- `reset_n` in 1: async active-low reset
- `new_game` in 1: one-cycle request to regenerate the whole sequence
- `show` in 1: one-cycle request to play back entries 0..`round`
- `round` in 5: current check round, the same value carried on `sigs.check_round`
- `segment` out [LEN-1:0][2:0]: colour sequence fed to `verify_input`
- `seg_valid` out 1: `segment` is complete and stable
- `led` out 4: one-hot playback LEDs
- `busy` out 1: generating or playing back
- `done` out 1: one-cycle pulse when playback ends

## Operation
- Colour encoding: 3'd1..3'd4 are colours 0..3; 3'd0 means empty slot. `led` = 4'b0001 << (code-1).
- LFSR: 16-bit Galois generator, taps 16'hB400. It advances every clock in every state and never reaches zero.
- States:
  - IDLE → GEN on `new_game`.
  - IDLE → ON on `show` && `seg_valid`.
  - GEN → IDLE after writing entry LEN-1.
  - ON → OFF after ON_CYCLES clocks.
  - OFF → ON (idx+1) when idx < round_eff.
  - OFF → IDLE with `done` pulse when idx == round_eff.
- GEN writes one entry per clock: `segment[idx] <= {1'b0, lfsr[1:0]} + 3'd1`, with idx running 0..LEN-1.
- round_eff is `round` clamped to LEN-1. It is latched on the edge that accepts `show`, so later changes to `round` have no effect.
- Arbitration and ignored requests:
  - `new_game` and `show` in the same IDLE cycle: `new_game` wins and `show` is dropped.
  - Both requests are ignored while `busy`.
  - `show` is ignored while `seg_valid`=0.
- `led` is driven only in ON and is 0 in all other states.
- Reset values: `segment` all 0, `seg_valid` 0, `led` 0, `busy` 0, `done` 0, state IDLE, LFSR = SEED.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. No partial sequence survives.

## Timing
- GEN: `seg_valid` drops on the edge that samples `new_game`, and `busy` rises on the same edge.
  - Entries are written on the next LEN edges.
  - `seg_valid` rises and `busy` falls on the edge that writes entry LEN-1, which is LEN clocks after acceptance.
- Playback: `led` is valid starting at the edge that accepts `show`.
  - Each entry is lit for exactly ON_CYCLES clocks, followed by OFF_CYCLES dark clocks.
  - `done` is high for the single cycle after the last OFF period, and `busy` is low in that same cycle.
  - Total time from acceptance to `done`: (round_eff+1)·(ON_CYCLES+OFF_CYCLES) clocks.
- Dwell counter width: $clog2(max(ON_CYCLES, OFF_CYCLES)). The counter resets to 0 on every state change.
- `segment` never changes outside GEN.

## Structure
- Package `simon_pkg` holds:
  - `colour_t` (logic [2:0]) and the constants COL_NONE/COL_0..COL_3
  - LEN default, LFSR_TAPS
  - `seq_state_t` enum {IDLE, GEN, ON, OFF}
- Sub-module `lfsr16`: ports `clk`, `reset_n`, `seed`, `q[15:0]`. It is free-running.
- The FSM, idx/dwell counters, `segment` register and LED decode live in `simon_sequencer`.

## Test plan
All benches use ON_CYCLES=3 and OFF_CYCLES=2.
- **Reset:** hold `reset_n`=0 → all outputs 0. Release, then pulse `new_game` → `busy`=1 for 32 clocks, then `seg_valid`=1. Every entry is in 1..4 and matches the bench LFSR model.
- **Playback:** `round`=2, pulse `show` → `led` pattern is 3 lit / 2 dark, three times. Each lit value equals onehot(segment[i]-1). `done` pulses exactly 15 clocks after acceptance.
- **Ignored requests and clamping:**
  - `show` before any `new_game` → no response; `led` stays 0.
  - `show` with `round`=31 → 32 entries, 160 clocks.
  - `round`=5'd31 is the maximum input, so clamping is exercised at the boundary.
- **Collisions:**
  - `new_game` and `show` in the same cycle → GEN only.
  - `new_game` during playback → ignored; `segment` unchanged.
  - Changing `round` mid-playback → no effect.
- **Async reset:** assert `reset_n`=0 in GEN at idx=10 and in ON at idx=1 → outputs clear immediately. A subsequent `new_game` works normally.
